alu_n_bit_seq: RTL and testbench

ALU_N_BIT_SEQ -- requirements
Module: alu_n_bit_seq

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_n_bit_comb.sv | 32 +++
 rtl/alu_n_bit_seq.sv | 149 ++++++++++++++
 tb/tb_alu_n_bit_seq.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and FSM state encoding shared by the ALU blocks
package alu_pkg;
  localparam logic [2:0] OPR_AND = 3'b000;
  localparam logic [2:0] OPR_OR  = 3'b001;
  localparam logic [2:0] OPR_ADD = 3'b010;
  localparam logic [2:0] OPR_SLT = 3'b011;
  localparam logic [2:0] OPR_MUL = 3'b100;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_MULT, ST_FIN} state_t;
endpackage

// File: rtl/alu_n_bit_comb.sv
// alu_n_bit_comb: single-cycle AND/OR/ADD/SLT datapath with overflow and carry flags
module alu_n_bit_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ainv,
  input  logic             bneg,
  input  logic [2:0]       opr,
  output logic [WIDTH-1:0] res,
  output logic             ovf,
  output logic             cout
);
  logic [WIDTH-1:0] ap, bp, sum;
  logic c_out, c_msb, v;
  // operand conditioning, adder, and result select; flags only meaningful for ADD
  always_comb begin
    ap = ainv ? ~a : a;
    bp = bneg ? ~b : b;
    {c_out, sum} = {1'b0, ap} + {1'b0, bp} + {{WIDTH{1'b0}}, bneg};
    c_msb = sum[WIDTH-1] ^ ap[WIDTH-1] ^ bp[WIDTH-1];
    v = c_msb ^ c_out;
    res = opr == OPR_AND ? ap & bp :
          opr == OPR_OR  ? ap | bp :
          opr == OPR_ADD ? sum :
          opr == OPR_SLT ? {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ v} : '0;
    ovf = (opr == OPR_ADD) && v;
    cout = (opr == OPR_ADD) && c_out;
  end
endmodule

// File: rtl/alu_n_bit_seq.sv
// alu_n_bit_seq: sequential ALU with start/done handshake and shift-add multiplier
module alu_n_bit_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             AINV,
  input  logic             BNEG,
  input  logic [2:0]       Opr,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             OVERFLOW,
  output logic             ZERO,
  output logic             COUT
);
  localparam int CW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, mhi_q, mhi_d, mlo_q, mlo_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, c_res, mhi_n, mlo_n;
  logic [2:0] opr_q, opr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] mstep;
  logic ainv_q, ainv_d, bneg_q, bneg_d, ready_q, ready_d, done_q, done_d;
  logic ovf_q, ovf_d, zero_q, zero_d, cout_q, cout_d, c_ovf, c_cout;

  alu_n_bit_comb #(.WIDTH(WIDTH)) u_comb (
    .a(ra_q), .b(rb_q), .ainv(ainv_q), .bneg(bneg_q), .opr(opr_q),
    .res(c_res), .ovf(c_ovf), .cout(c_cout)
  );

  // next-state: capture in IDLE, one-cycle CALC, WIDTH-step shift-add MULT, one-cycle FIN
  always_comb begin
    state_d = state_q;
    ra_d = ra_q;
    rb_d = rb_q;
    ainv_d = ainv_q;
    bneg_d = bneg_q;
    opr_d = opr_q;
    mhi_d = mhi_q;
    mlo_d = mlo_q;
    cnt_d = cnt_q;
    res_d = res_q;
    hi_d = hi_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
    cout_d = cout_q;
    ready_d = ready_q;
    done_d = 1'b0;
    mstep = mlo_q[0] ? {1'b0, mhi_q} + {1'b0, ra_q} : {1'b0, mhi_q};
    mhi_n = mstep[WIDTH:1];
    mlo_n = {mstep[0], mlo_q[WIDTH-1:1]};
    case (state_q)
      ST_IDLE: if (START) begin
        ra_d = A;
        rb_d = B;
        ainv_d = AINV;
        bneg_d = BNEG;
        opr_d = Opr;
        mhi_d = '0;
        mlo_d = B;
        cnt_d = '0;
        ready_d = 1'b0;
        state_d = (Opr == OPR_MUL && MUL_EN) ? ST_MULT : ST_CALC;
      end
      ST_CALC: begin
        res_d = c_res;
        hi_d = '0;
        ovf_d = c_ovf;
        cout_d = c_cout;
        zero_d = c_res == '0;
        done_d = 1'b1;
        state_d = ST_FIN;
      end
      ST_MULT: begin
        mhi_d = mhi_n;
        mlo_d = mlo_n;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_d = mlo_n;
          hi_d = mhi_n;
          ovf_d = 1'b0;
          cout_d = 1'b0;
          zero_d = {mhi_n, mlo_n} == '0;
          done_d = 1'b1;
          state_d = ST_FIN;
        end
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and registered outputs, cleared asynchronously by RESETB
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= ST_IDLE;
      ra_q <= '0;
      rb_q <= '0;
      ainv_q <= 1'b0;
      bneg_q <= 1'b0;
      opr_q <= OPR_AND;
      mhi_q <= '0;
      mlo_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      hi_q <= '0;
      ovf_q <= 1'b0;
      zero_q <= 1'b1;
      cout_q <= 1'b0;
      ready_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      ainv_q <= ainv_d;
      bneg_q <= bneg_d;
      opr_q <= opr_d;
      mhi_q <= mhi_d;
      mlo_q <= mlo_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      hi_q <= hi_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
      cout_q <= cout_d;
      ready_q <= ready_d;
      done_q <= done_d;
    end
  end

  assign READY = ready_q;
  assign DONE = done_q;
  assign RESULT = res_q;
  assign RESULT_HI = hi_q;
  assign OVERFLOW = ovf_q;
  assign ZERO = zero_q;
  assign COUT = cout_q;
endmodule

// File: tb/tb_alu_n_bit_seq.sv
// tb_alu_n_bit_seq: directed table, corner sequences and random checks against an arithmetic model
module tb_alu_n_bit_seq;
  logic CLK, RESETB, START, AINV, BNEG, READY, DONE, OVERFLOW, ZERO, COUT;
  logic [7:0] A, B, RESULT, RESULT_HI;
  logic [2:0] Opr;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    logic ai, bn;
    logic [7:0] r, h;
    logic o, z, c;
  } vec_t;

  vec_t tbl[9];

  alu_n_bit_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .CLK(CLK), .RESETB(RESETB), .START(START), .A(A), .B(B),
    .AINV(AINV), .BNEG(BNEG), .Opr(Opr), .READY(READY), .DONE(DONE),
    .RESULT(RESULT), .RESULT_HI(RESULT_HI), .OVERFLOW(OVERFLOW),
    .ZERO(ZERO), .COUT(COUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t m = v;
    int ap, bp, cin, u, sa, sb, s, p;
    ap = v.ai ? (~int'(v.a)) & 255 : int'(v.a);
    bp = v.bn ? (~int'(v.b)) & 255 : int'(v.b);
    cin = v.bn ? 1 : 0;
    u = ap + bp + cin;
    sa = ap > 127 ? ap - 256 : ap;
    sb = bp > 127 ? bp - 256 : bp;
    s = sa + sb + cin;
    m.h = 8'h00;
    m.o = 1'b0;
    m.c = 1'b0;
    case (v.op)
      3'd0: m.r = 8'(ap & bp);
      3'd1: m.r = 8'(ap | bp);
      3'd2: begin
        m.r = 8'(u & 255);
        m.c = u > 255;
        m.o = (s > 127) || (s < -128);
      end
      3'd3: m.r = s < 0 ? 8'd1 : 8'd0;
      3'd4: begin
        p = int'(v.a) * int'(v.b);
        m.r = 8'(p & 255);
        m.h = 8'(p >> 8);
      end
      default: m.r = 8'h00;
    endcase
    m.z = (m.r == 0) && (m.h == 0);
    return m;
  endfunction

  // called at a falling edge; returns at a falling edge with the DUT back in IDLE
  task automatic run(input vec_t v, input bit poke, input string nm);
    int edges;
    int lat;
    lat = (v.op == 3'b100) ? 9 : 2;
    START = 1'b1; A = v.a; B = v.b; AINV = v.ai; BNEG = v.bn; Opr = v.op;
    @(posedge CLK); #1;
    START = 1'b0;
    edges = 1;
    chk({nm, "_busy"}, READY, 0);
    while (!DONE && edges < 40) begin
      if (poke && edges == 3) begin START = 1'b1; A = 8'h01; B = 8'h01; Opr = 3'b010; end
      if (poke && edges == 5) START = 1'b0;
      @(posedge CLK); #1;
      edges++;
    end
    chk({nm, "_latency"}, edges, lat);
    chk({nm, "_result"}, RESULT, v.r);
    chk({nm, "_result_hi"}, RESULT_HI, v.h);
    chk({nm, "_overflow"}, OVERFLOW, v.o);
    chk({nm, "_zero"}, ZERO, v.z);
    chk({nm, "_cout"}, COUT, v.c);
    @(posedge CLK); #1;
    chk({nm, "_done_pulse"}, DONE, 0);
    chk({nm, "_ready"}, READY, 1);
    @(posedge CLK); #1;
    chk({nm, "_no_requeue"}, DONE, 0);
    chk({nm, "_hold"}, RESULT, v.r);
    @(negedge CLK);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{3'b010, 8'd200, 8'd100, 1'b0, 1'b0, 8'd44, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{3'b010, 8'h50, 8'hB0, 1'b0, 1'b1, 8'hA0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{3'b010, 8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{3'b011, 8'hFD, 8'h02, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{3'b011, 8'h7F, 8'h80, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{3'b000, 8'h0F, 8'hF0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{3'b001, 8'h0C, 8'h30, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{3'b111, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{3'b100, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0};
    RESETB = 1'b0; START = 1'b0; A = 8'h00; B = 8'h00; AINV = 1'b0; BNEG = 1'b0; Opr = 3'b000;
    #12;
    chk("rst_ready", READY, 1);
    chk("rst_done", DONE, 0);
    chk("rst_result", RESULT, 0);
    chk("rst_result_hi", RESULT_HI, 0);
    chk("rst_zero", ZERO, 1);
    chk("rst_overflow", OVERFLOW, 0);
    chk("rst_cout", COUT, 0);
    @(negedge CLK);
    RESETB = 1'b1;
    for (int i = 0; i < 9; i++) run(tbl[i], 1'b0, $sformatf("vec%0d", i));
    run(tbl[8], 1'b1, "mul_poke");
    run(tbl[0], 1'b0, "pre_abort");
    START = 1'b1; A = 8'h12; B = 8'h34; Opr = 3'b100;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #3;
    RESETB = 1'b0;
    #1;
    chk("abort_ready", READY, 1);
    chk("abort_done", DONE, 0);
    chk("abort_result", RESULT, 0);
    chk("abort_result_hi", RESULT_HI, 0);
    chk("abort_zero", ZERO, 1);
    chk("abort_cout", COUT, 0);
    @(negedge CLK);
    RESETB = 1'b1;
    run(tbl[5], 1'b0, "post_abort_nor");
    for (int i = 0; i < 150; i++) begin
      v.op = 3'($urandom_range(0, 7));
      v.a = 8'($urandom);
      v.b = 8'($urandom);
      v.ai = 1'($urandom);
      v.bn = 1'($urandom);
      v = model(v);
      run(v, 1'b0, $sformatf("rnd%0d_op%0d", i, v.op));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
